// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants for the instruction-fetch front end.
package riscv_pkg;

    localparam int          IMEM_ADDR_W = 9;
    localparam int          FETCH_DEPTH = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef struct packed {
        logic [IMEM_ADDR_W-1:0] pc;
        logic [31:0]            instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_unit_fifo.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO of {pc, instr} with flush.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = FETCH_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  fetch_entry_t       wdata,
    output fetch_entry_t       rdata,
    output logic [CNT_W-1:0]   count,
    output logic               empty
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: storage has no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: PC generation, credit-limited imem requests,
// prefetch buffering, redirect flush with in-flight discard, and halt drain.
module if_prefetch_unit
    import riscv_pkg::*;
#(
    parameter int               ADDR_W   = IMEM_ADDR_W,  // must match fetch_entry_t.pc
    parameter int               DEPTH    = FETCH_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              halted
);

    localparam int              CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]  DEPTH_CNT = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [ADDR_W-1:0] last_pc;
    logic [ADDR_W-1:0] target_pc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  outstanding_next;
    logic [CNT_W-1:0]  discard_cnt;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    in_flight;
    logic              halt_latched;
    logic              fifo_empty;
    logic              grant;
    logic              dropping;
    logic              push;
    logic              pop;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;

    // Buffered plus outstanding words may never exceed DEPTH, so a push always fits.
    assign in_flight = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req  = !reset && !halt_latched && (in_flight < DEPTH_CNT);
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;

    assign outstanding_next = outstanding + CNT_W'(grant) - CNT_W'(imem_rvalid);
    assign dropping         = imem_rvalid && (discard_cnt != '0);
    assign push             = imem_rvalid && !dropping && !redirect;
    assign pop              = !fifo_empty && !stall && !redirect;
    assign target_pc        = redirect_pc & ~ADDR_W'(3);

    assign push_entry.pc    = resp_pc;
    assign push_entry.instr = imem_rdata;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (push_entry),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc     <= RESET_PC;
            resp_pc      <= RESET_PC;
            last_pc      <= RESET_PC;
            outstanding  <= '0;
            discard_cnt  <= '0;
            halt_latched <= 1'b0;
        end else begin
            outstanding <= outstanding_next;
            if (halt)
                halt_latched <= 1'b1;
            if (pop)
                last_pc <= head.pc;
            // Every word still in flight after this edge belongs to the old stream.
            if (redirect) begin
                fetch_pc    <= target_pc;
                resp_pc     <= target_pc;
                discard_cnt <= outstanding_next;
            end else begin
                if (grant)
                    fetch_pc <= fetch_pc + ADDR_W'(4);
                if (push)
                    resp_pc <= resp_pc + ADDR_W'(4);
                if (dropping)
                    discard_cnt <= discard_cnt - 1'b1;
            end
        end
    end

    assign if_valid = !fifo_empty;
    assign if_instr = fifo_empty ? NOP_INSTR : head.instr;
    assign if_pc    = fifo_empty ? last_pc : head.pc;
    assign halted   = halt_latched && fifo_empty && (outstanding == '0);

endmodule
